get_flag_gen: RTL and testbench
===============================

Name: get_flag_gen

Overview:
- Parametrised successor of the flag locator.
- Phase 1 (ring): samples RING_PTS points at ROM-supplied offsets around (ctr_coords_x, ctr_coords_y) and averages the coordinates of ring points matching a selected polarity. The result is the orientation point.
- Phase 2 (window): scans a WIN x WIN window centred on the orientation point and averages the coordinates of matching points. The result is the flag centre.
- Sits between the top-level controller and the pixel-access logic. Adds a shared sequential divider, handshake timeout, zero-count error reporting and run-time polarity selection.

Parameters:
- COORD_W, 10: coordinate width; all coordinate arithmetic is modulo 2^COORD_W.
- RING_PTS, 536: number of ring offsets; ROM addresses run 0..RING_PTS-1.
- ADDR_W, 10: ring ROM address width; requires 2^ADDR_W >= RING_PTS.
- WIN, 16: window edge length; even, >= 2.
- SUM_W, 32: accumulator and point-counter width.
- TIMEOUT, 1023: maximum cycles pt_req may wait for pt_valid.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- start  in  1  single-cycle start pulse; ignored unless idle
- ring_sel  in  1  ring polarity counted (captured at start)
- win_sel  in  1  window polarity counted (captured at start)
- ctr_coords_x  in  COORD_W  ring centre x (captured at start)
- ctr_coords_y  in  COORD_W  ring centre y (captured at start)
- rom_addr  out  ADDR_W  ring offset ROM address
- rom_dx  in  COORD_W  two's-complement x offset, valid one cycle after rom_addr
- rom_dy  in  COORD_W  two's-complement y offset, valid one cycle after rom_addr
- pt_coords_x  out  COORD_W  requested point x
- pt_coords_y  out  COORD_W  requested point y
- pt_req  out  1  point request, level
- pt_valid  in  1  point value valid, single-cycle
- pt_value  in  1  point value
- orien_coords_x  out  COORD_W  phase-1 result x
- orien_coords_y  out  COORD_W  phase-1 result y
- flag_coords_x  out  COORD_W  flag centre x
- flag_coords_y  out  COORD_W  flag centre y
- busy  out  1  high from the cycle after an accepted start until complete
- complete  out  1  single-cycle done pulse
- error  out  1  valid with complete; 1 means the run failed
- err_code  out  2  0 ok, 1 ring count zero, 2 window count zero, 3 timeout

Behaviour:
- Reset: state IDLE; rom_addr, pt_coords, pt_req, busy, complete, error, err_code, orien_coords and flag_coords all 0; accumulators and counters 0.
- States: IDLE, R_ADDR, R_REQ, R_WAIT, R_DIV, W_INIT, W_REQ, W_WAIT, W_DIV, REPORT.
- IDLE:
  - start=1 captures the inputs, clears sums, count and index, and goes to R_ADDR.
  - start is ignored in every other state.
- R_ADDR: drive rom_addr=idx; go to R_REQ.
- R_REQ:
  - pt_coords = ctr + sign-extended rom offset, modulo 2^COORD_W (wraps, no saturation).
  - pt_req<=1; go to R_WAIT.
- Handshake (R_WAIT and W_WAIT):
  - pt_req stays high until pt_valid=1 is sampled; pt_value is sampled in that same cycle; pt_req drops on the next edge.
  - pt_valid arriving while pt_req=0 is ignored.
  - The wait counter counts cycles in the wait state. When it reaches TIMEOUT without pt_valid: pt_req<=0, err_code=3, go to REPORT.
- R_WAIT on pt_valid:
  - If pt_value==ring_sel: sum_x+=pt_coords_x, sum_y+=pt_coords_y, cnt+=1 (zero-extended).
  - If idx==RING_PTS-1 go to R_DIV; else idx+=1 and go to R_ADDR.
- R_DIV:
  - cnt==0: err_code=1, go to REPORT; no window requests are issued.
  - Otherwise run a restoring divide, one quotient bit per cycle, SUM_W cycles for x then SUM_W cycles for y (single shared divider, floor quotient).
  - orien_coords <= quotient[COORD_W-1:0]; go to W_INIT.
- W_INIT:
  - base = orien - WIN/2 modulo 2^COORD_W.
  - Clear sums and count; wx=wy=0.
- W_REQ: pt_coords = base + (wx, wy) modulo 2^COORD_W; pt_req<=1; go to W_WAIT.
- W_WAIT on pt_valid:
  - If pt_value==win_sel, accumulate as in the ring phase.
  - Scan order is x fastest: wx wraps WIN-1→0 and increments wy.
  - After (WIN-1, WIN-1) go to W_DIV; otherwise return to W_REQ.
- W_DIV:
  - cnt==0: err_code=2, flag_coords unchanged.
  - Otherwise divide as in R_DIV and load flag_coords.
  - Go to REPORT.
- REPORT: complete=1 and error=(err_code!=0) for exactly one cycle; busy drops in the same cycle; next state IDLE. err_code holds until the next accepted start.
- Minimum per-point cost: 3 cycles on the ring, 2 in the window, when pt_valid arrives one cycle after pt_req rises.
- Reset mid-operation: pt_req falls on that edge; no complete pulse.

Test Plan:
1. RING_PTS=4, WIN=4, offsets (5,0),(0,5),(-5,0),(0,-5), ctr=(100,100), ring_sel=0, responder returns 0 on ring and 1 in window, win_sel=1 -> orien=(100,100); 16 window requests covering x,y 98..101; flag=(99,99); error=0; one complete pulse.
2. Same configuration with ring responder returning all 1 -> exactly 4 ring requests, no window requests; complete with error=1, err_code=1; flag_coords keep their previous values.
3. ctr=(1,1), offset (-5,-5) -> first pt_coords=(1020,1020) with COORD_W=10.
4. Responder withholds pt_valid on the 3rd ring point -> pt_req drops after exactly TIMEOUT wait cycles; complete with err_code=3.
5. Assert rst 2 cycles into W_WAIT -> next cycle pt_req=0, busy=0, all outputs 0; a fresh start then runs normally.
6. Pulse start again during R_WAIT -> ignored; the capture from the first start is unchanged and only one complete pulse is produced.

Source files
------------

// File: rtl/get_flag_gen.sv
// Flag locator: averages matching ring points to find an orientation point, then
// averages matching points of a WIN x WIN window around it to find the flag centre.
module get_flag_gen #(
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned RING_PTS = 536,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned WIN      = 16,
  parameter int unsigned SUM_W    = 32,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ring_sel,
  input  logic               win_sel,
  input  logic [COORD_W-1:0] ctr_coords_x,
  input  logic [COORD_W-1:0] ctr_coords_y,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COORD_W-1:0] rom_dx,
  input  logic [COORD_W-1:0] rom_dy,
  output logic [COORD_W-1:0] pt_coords_x,
  output logic [COORD_W-1:0] pt_coords_y,
  output logic               pt_req,
  input  logic               pt_valid,
  input  logic               pt_value,
  output logic [COORD_W-1:0] orien_coords_x,
  output logic [COORD_W-1:0] orien_coords_y,
  output logic [COORD_W-1:0] flag_coords_x,
  output logic [COORD_W-1:0] flag_coords_y,
  output logic               busy,
  output logic               complete,
  output logic               error,
  output logic [1:0]         err_code
);

  localparam int unsigned WIN_W = (WIN > 2) ? $clog2(WIN) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned BIT_W = $clog2(SUM_W);

  typedef enum logic [3:0] {
    IDLE, R_ADDR, R_REQ, R_WAIT, R_DIV, W_INIT, W_REQ, W_WAIT, W_DIV, REPORT
  } state_t;

  state_t             state_q, state_d;
  logic               ring_sel_q, ring_sel_d, win_sel_q, win_sel_d;
  logic [COORD_W-1:0] ctr_x_q, ctr_x_d, ctr_y_q, ctr_y_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [COORD_W-1:0] pt_x_q, pt_x_d, pt_y_q, pt_y_d;
  logic               pt_req_q, pt_req_d;
  logic [TMO_W-1:0]   wait_q, wait_d;
  logic [SUM_W-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d, cnt_q, cnt_d;
  logic [COORD_W-1:0] base_x_q, base_x_d, base_y_q, base_y_d;
  logic [WIN_W-1:0]   wx_q, wx_d, wy_q, wy_d;
  logic               div_run_q, div_run_d, div_axis_q, div_axis_d;
  logic [BIT_W-1:0]   div_bit_q, div_bit_d;
  logic [SUM_W-1:0]   div_num_q, div_num_d, div_rem_q, div_rem_d;
  logic [COORD_W-1:0] div_quo_q, div_quo_d, quo_x_q, quo_x_d;
  logic [COORD_W-1:0] orien_x_q, orien_x_d, orien_y_q, orien_y_d;
  logic [COORD_W-1:0] flag_x_q, flag_x_d, flag_y_q, flag_y_d;
  logic               busy_q, busy_d, complete_q, complete_d, error_q, error_d;
  logic [1:0]         err_code_q, err_code_d;

  // One restoring-divide step; rem < cnt always, so SUM_W bits hold it between steps.
  logic [SUM_W:0]     rem_sh;
  logic               div_ge;
  logic [SUM_W-1:0]   rem_nxt;
  logic [COORD_W-1:0] quo_nxt;

  always_comb begin
    rem_sh  = {div_rem_q, div_num_q[SUM_W-1]};
    div_ge  = (rem_sh >= {1'b0, cnt_q});
    rem_nxt = div_ge ? SUM_W'(rem_sh - {1'b0, cnt_q}) : SUM_W'(rem_sh);
    quo_nxt = COORD_W'({div_quo_q, div_ge});
  end

  always_comb begin
    state_d    = state_q;    ring_sel_d = ring_sel_q; win_sel_d  = win_sel_q;
    ctr_x_d    = ctr_x_q;    ctr_y_d    = ctr_y_q;    idx_d      = idx_q;
    pt_x_d     = pt_x_q;     pt_y_d     = pt_y_q;     pt_req_d   = pt_req_q;
    wait_d     = wait_q;     sum_x_d    = sum_x_q;    sum_y_d    = sum_y_q;
    cnt_d      = cnt_q;      base_x_d   = base_x_q;   base_y_d   = base_y_q;
    wx_d       = wx_q;       wy_d       = wy_q;       div_run_d  = div_run_q;
    div_axis_d = div_axis_q; div_bit_d  = div_bit_q;  div_num_d  = div_num_q;
    div_rem_d  = div_rem_q;  div_quo_d  = div_quo_q;  quo_x_d    = quo_x_q;
    orien_x_d  = orien_x_q;  orien_y_d  = orien_y_q;  flag_x_d   = flag_x_q;
    flag_y_d   = flag_y_q;   busy_d     = busy_q;     complete_d = complete_q;
    error_d    = error_q;    err_code_d = err_code_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ring_sel_d = ring_sel;     win_sel_d = win_sel;
          ctr_x_d    = ctr_coords_x; ctr_y_d   = ctr_coords_y;
          sum_x_d    = '0; sum_y_d = '0; cnt_d = '0; idx_d = '0;
          err_code_d = 2'd0;
          busy_d     = 1'b1;
          state_d    = R_ADDR;
        end
      end
      R_ADDR: state_d = R_REQ;
      R_REQ: begin
        pt_x_d   = ctr_x_q + rom_dx;
        pt_y_d   = ctr_y_q + rom_dy;
        pt_req_d = 1'b1;
        wait_d   = '0;
        state_d  = R_WAIT;
      end
      R_WAIT, W_WAIT: begin
        if (pt_valid) begin
          pt_req_d = 1'b0;
          if (pt_value == ((state_q == R_WAIT) ? ring_sel_q : win_sel_q)) begin
            sum_x_d = sum_x_q + SUM_W'(pt_x_q);
            sum_y_d = sum_y_q + SUM_W'(pt_y_q);
            cnt_d   = cnt_q + SUM_W'(1);
          end
          if (state_q == R_WAIT) begin
            if (idx_q == ADDR_W'(RING_PTS - 1)) begin
              state_d = R_DIV;
            end else begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = R_ADDR;
            end
          end else if (wx_q == WIN_W'(WIN - 1)) begin
            wx_d    = '0;
            wy_d    = wy_q + WIN_W'(1);
            state_d = (wy_q == WIN_W'(WIN - 1)) ? W_DIV : W_REQ;
          end else begin
            wx_d    = wx_q + WIN_W'(1);
            state_d = W_REQ;
          end
        end else if (wait_q == TMO_W'(TIMEOUT - 1)) begin
          pt_req_d   = 1'b0;
          err_code_d = 2'd3;
          state_d    = REPORT;
        end else begin
          wait_d = wait_q + TMO_W'(1);
        end
      end
      // First cycle checks the count and loads x; each further cycle retires one quotient bit.
      R_DIV, W_DIV: begin
        if (!div_run_q) begin
          if (cnt_q == '0) begin
            err_code_d = (state_q == R_DIV) ? 2'd1 : 2'd2;
            state_d    = REPORT;
          end else begin
            div_run_d  = 1'b1; div_axis_d = 1'b0; div_bit_d = '0;
            div_num_d  = sum_x_q; div_rem_d = '0;
          end
        end else begin
          div_num_d = div_num_q << 1;
          div_rem_d = rem_nxt;
          div_quo_d = quo_nxt;
          div_bit_d = div_bit_q + BIT_W'(1);
          if (div_bit_q == BIT_W'(SUM_W - 1)) begin
            if (!div_axis_q) begin
              quo_x_d    = quo_nxt;
              div_axis_d = 1'b1; div_bit_d = '0;
              div_num_d  = sum_y_q; div_rem_d = '0;
            end else begin
              div_run_d = 1'b0;
              if (state_q == R_DIV) begin
                orien_x_d = quo_x_q; orien_y_d = quo_nxt;
                state_d   = W_INIT;
              end else begin
                flag_x_d = quo_x_q; flag_y_d = quo_nxt;
                state_d  = REPORT;
              end
            end
          end
        end
      end
      W_INIT: begin
        base_x_d = orien_x_q - COORD_W'(WIN / 2);
        base_y_d = orien_y_q - COORD_W'(WIN / 2);
        sum_x_d  = '0; sum_y_d = '0; cnt_d = '0;
        wx_d     = '0; wy_d = '0;
        state_d  = W_REQ;
      end
      W_REQ: begin
        pt_x_d   = base_x_q + COORD_W'(wx_q);
        pt_y_d   = base_y_q + COORD_W'(wy_q);
        pt_req_d = 1'b1;
        wait_d   = '0;
        state_d  = W_WAIT;
      end
      REPORT: begin
        complete_d = 1'b0;
        error_d    = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Completion pulse is raised on the edge that enters REPORT.
    if (state_d == REPORT && state_q != REPORT) begin
      complete_d = 1'b1;
      busy_d     = 1'b0;
      error_d    = (err_code_d != 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE; ring_sel_q <= 1'b0; win_sel_q  <= 1'b0;
      ctr_x_q    <= '0;   ctr_y_q    <= '0;   idx_q      <= '0;
      pt_x_q     <= '0;   pt_y_q     <= '0;   pt_req_q   <= 1'b0;
      wait_q     <= '0;   sum_x_q    <= '0;   sum_y_q    <= '0;
      cnt_q      <= '0;   base_x_q   <= '0;   base_y_q   <= '0;
      wx_q       <= '0;   wy_q       <= '0;   div_run_q  <= 1'b0;
      div_axis_q <= 1'b0; div_bit_q  <= '0;   div_num_q  <= '0;
      div_rem_q  <= '0;   div_quo_q  <= '0;   quo_x_q    <= '0;
      orien_x_q  <= '0;   orien_y_q  <= '0;   flag_x_q   <= '0;
      flag_y_q   <= '0;   busy_q     <= 1'b0; complete_q <= 1'b0;
      error_q    <= 1'b0; err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;    ring_sel_q <= ring_sel_d; win_sel_q  <= win_sel_d;
      ctr_x_q    <= ctr_x_d;    ctr_y_q    <= ctr_y_d;    idx_q      <= idx_d;
      pt_x_q     <= pt_x_d;     pt_y_q     <= pt_y_d;     pt_req_q   <= pt_req_d;
      wait_q     <= wait_d;     sum_x_q    <= sum_x_d;    sum_y_q    <= sum_y_d;
      cnt_q      <= cnt_d;      base_x_q   <= base_x_d;   base_y_q   <= base_y_d;
      wx_q       <= wx_d;       wy_q       <= wy_d;       div_run_q  <= div_run_d;
      div_axis_q <= div_axis_d; div_bit_q  <= div_bit_d;  div_num_q  <= div_num_d;
      div_rem_q  <= div_rem_d;  div_quo_q  <= div_quo_d;  quo_x_q    <= quo_x_d;
      orien_x_q  <= orien_x_d;  orien_y_q  <= orien_y_d;  flag_x_q   <= flag_x_d;
      flag_y_q   <= flag_y_d;   busy_q     <= busy_d;     complete_q <= complete_d;
      error_q    <= error_d;    err_code_q <= err_code_d;
    end
  end

  assign rom_addr       = idx_q;
  assign pt_coords_x    = pt_x_q;
  assign pt_coords_y    = pt_y_q;
  assign pt_req         = pt_req_q;
  assign orien_coords_x = orien_x_q;
  assign orien_coords_y = orien_y_q;
  assign flag_coords_x  = flag_x_q;
  assign flag_coords_y  = flag_y_q;
  assign busy           = busy_q;
  assign complete       = complete_q;
  assign error          = error_q;
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_get_flag_gen.sv
// Scoreboard bench for get_flag_gen: a reference model queues expected point
// requests and results; monitors queue what the DUT produces.
module tb_get_flag_gen;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned RING_PTS = 4;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned WIN      = 4;
  localparam int unsigned SUM_W    = 32;
  localparam int unsigned TIMEOUT  = 30;
  localparam int M  = 1 << COORD_W;
  localparam int NR = RING_PTS;
  localparam int NW = WIN;

  typedef struct packed {
    logic               err;
    logic [1:0]         code;
    logic [COORD_W-1:0] ox, oy, fx, fy;
  } res_t;

  logic clk = 1'b0;
  logic rst, start, ring_sel, win_sel, pt_req, pt_valid, pt_value;
  logic busy, complete, error;
  logic [1:0] err_code;
  logic [ADDR_W-1:0] rom_addr;
  logic [COORD_W-1:0] ctr_coords_x, ctr_coords_y, rom_dx, rom_dy, pt_coords_x, pt_coords_y;
  logic [COORD_W-1:0] orien_coords_x, orien_coords_y, flag_coords_x, flag_coords_y;

  int n_cmp = 0;
  int n_bad = 0;
  int tbl_dx[NR];
  int tbl_dy[NR];
  bit ring_val, win_val;
  int hold_num = -1;
  int req_in_run = 0;
  int hold_cyc = 0;
  int n_complete = 0;
  int m_ox = 0, m_oy = 0, m_fx = 0, m_fy = 0;
  logic [2*COORD_W-1:0] exp_req_q[$], obs_req_q[$];
  res_t exp_res_q[$], obs_res_q[$];

  get_flag_gen #(.COORD_W(COORD_W), .RING_PTS(RING_PTS), .ADDR_W(ADDR_W), .WIN(WIN),
                 .SUM_W(SUM_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .ring_sel(ring_sel), .win_sel(win_sel),
    .ctr_coords_x(ctr_coords_x), .ctr_coords_y(ctr_coords_y), .rom_addr(rom_addr),
    .rom_dx(rom_dx), .rom_dy(rom_dy), .pt_coords_x(pt_coords_x), .pt_coords_y(pt_coords_y),
    .pt_req(pt_req), .pt_valid(pt_valid), .pt_value(pt_value),
    .orien_coords_x(orien_coords_x), .orien_coords_y(orien_coords_y),
    .flag_coords_x(flag_coords_x), .flag_coords_y(flag_coords_y),
    .busy(busy), .complete(complete), .error(error), .err_code(err_code));

  always #5 clk = ~clk;

  // Offset ROM with one cycle of read latency.
  initial begin
    logic [ADDR_W-1:0] a;
    a = '0; rom_dx = '0; rom_dy = '0;
    forever begin
      @(negedge clk); a = rom_addr;
      @(posedge clk); #1;
      rom_dx = COORD_W'(tbl_dx[int'(a) % NR]);
      rom_dy = COORD_W'(tbl_dy[int'(a) % NR]);
    end
  end

  // Point responder: answers each new request one cycle after it rises unless held.
  initial begin
    bit prev;
    prev = 1'b0; pt_valid = 1'b0; pt_value = 1'b0;
    forever begin
      @(posedge clk); #1;
      pt_valid = 1'b0;
      if (rst) prev = 1'b0;
      else begin
        if (pt_req && !prev) begin
          obs_req_q.push_back({pt_coords_x, pt_coords_y});
          if (req_in_run == hold_num) hold_cyc = 1;
          else begin
            pt_valid = 1'b1;
            pt_value = (req_in_run < NR) ? ring_val : win_val;
          end
          req_in_run++;
        end else if (pt_req && (req_in_run - 1) == hold_num) hold_cyc++;
        prev = pt_req;
      end
    end
  end

  // Result monitor.
  initial forever begin
    res_t r;
    @(posedge clk); #1;
    if (complete) begin
      r = {error, err_code, orien_coords_x, orien_coords_y, flag_coords_x, flag_coords_y};
      obs_res_q.push_back(r);
      n_complete++;
    end
  end

  function automatic int wrap(input int v);
    return ((v % M) + M) % M;
  endfunction

  // Reference model: every point of a phase returns the same value.
  task automatic expect_run(input int cx, input int cy, input bit rs, input bit ws,
                            input bit rv, input bit wv, input int hold);
    int sx, sy, px, py, bx, by;
    res_t r;
    sx = 0; sy = 0; r = '0;
    for (int i = 0; i < NR; i++) begin
      px = wrap(cx + tbl_dx[i]); py = wrap(cy + tbl_dy[i]);
      exp_req_q.push_back({COORD_W'(px), COORD_W'(py)});
      if (i == hold) begin r.code = 2'd3; break; end
      sx += px; sy += py;
    end
    if (r.code == 2'd0 && rv != rs) r.code = 2'd1;
    if (r.code == 2'd0) begin
      m_ox = sx / NR; m_oy = sy / NR;
      bx = wrap(m_ox - NW / 2); by = wrap(m_oy - NW / 2);
      sx = 0; sy = 0;
      for (int wy = 0; wy < NW; wy++)
        for (int wx = 0; wx < NW; wx++) begin
          px = wrap(bx + wx); py = wrap(by + wy);
          exp_req_q.push_back({COORD_W'(px), COORD_W'(py)});
          sx += px; sy += py;
        end
      if (wv != ws) r.code = 2'd2;
      else begin m_fx = sx / (NW * NW); m_fy = sy / (NW * NW); end
    end
    r.err = (r.code != 2'd0);
    r.ox = COORD_W'(m_ox); r.oy = COORD_W'(m_oy);
    r.fx = COORD_W'(m_fx); r.fy = COORD_W'(m_fy);
    exp_res_q.push_back(r);
  endtask

  task automatic start_run(input int cx, input int cy, input bit rs, input bit ws,
                           input bit rv, input bit wv);
    @(negedge clk);
    ctr_coords_x = COORD_W'(cx); ctr_coords_y = COORD_W'(cy);
    ring_sel = rs; win_sel = ws; ring_val = rv; win_val = wv;
    req_in_run = 0; hold_cyc = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (n_complete != n0) ok = 1'b1;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ring_sel = 1'b0; win_sel = 1'b0;
    ctr_coords_x = '0; ctr_coords_y = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({pt_req, busy, complete, error, err_code} !== 6'b0) begin
      n_bad++; $display("FAIL rst_ctrl got %b want 000000", {pt_req, busy, complete, error, err_code});
    end
    n_cmp++;
    if ({rom_addr, pt_coords_x, pt_coords_y} !== '0) begin
      n_bad++; $display("FAIL rst_addr got %h want 0", {rom_addr, pt_coords_x, pt_coords_y});
    end
    n_cmp++;
    if ({orien_coords_x, orien_coords_y, flag_coords_x, flag_coords_y} !== '0) begin
      n_bad++; $display("FAIL rst_coords got %h want 0",
                        {orien_coords_x, orien_coords_y, flag_coords_x, flag_coords_y});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    bit ok;
    int n0;
    res_t e, o;
    tbl_dx = '{5, 0, -5, 0}; tbl_dy = '{0, 5, 0, -5};
    expect_run(100, 100, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    n0 = n_complete;
    start_run(100, 100, 1'b0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL nom_busy got %b want 1", busy); end
    wait_done(n0, ok);
    n_cmp++;
    if (!ok || n_complete - n0 != 1) begin
      n_bad++; $display("FAIL nom_done got %0d pulses want 1", n_complete - n0);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL nom_idle_busy got %b want 0", busy); end
    n_cmp++;
    if (obs_req_q.size() != exp_req_q.size()) begin
      n_bad++; $display("FAIL nom_nreq got %0d want %0d", obs_req_q.size(), exp_req_q.size());
    end
    while (exp_req_q.size() > 0 && obs_req_q.size() > 0) begin
      n_cmp++;
      if (obs_req_q[0] !== exp_req_q[0]) begin
        n_bad++; $display("FAIL nom_req got %h want %h", obs_req_q[0], exp_req_q[0]);
      end
      void'(obs_req_q.pop_front()); void'(exp_req_q.pop_front());
    end
    while (exp_res_q.size() > 0 && obs_res_q.size() > 0) begin
      e = exp_res_q.pop_front(); o = obs_res_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL nom_res got %h want %h", o, e); end
      n_cmp++;
      if (o.ox !== 10'd100 || o.oy !== 10'd100 || o.fx !== 10'd99 || o.fy !== 10'd99 || o.err !== 1'b0) begin
        n_bad++; $display("FAIL nom_vals got (%0d,%0d)/(%0d,%0d) err %b want (100,100)/(99,99) err 0",
                          o.ox, o.oy, o.fx, o.fy, o.err);
      end
    end
    exp_req_q.delete(); obs_req_q.delete(); exp_res_q.delete(); obs_res_q.delete();
  endtask

  task automatic test_ring_zero();
    bit ok;
    int n0;
    res_t e, o;
    expect_run(100, 100, 1'b0, 1'b1, 1'b1, 1'b1, -1);
    n0 = n_complete;
    start_run(100, 100, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_done(n0, ok);
    n_cmp++;
    if (!ok || obs_req_q.size() != NR) begin
      n_bad++; $display("FAIL rz_nreq got %0d done %b want %0d", obs_req_q.size(), ok, NR);
    end
    while (exp_res_q.size() > 0 && obs_res_q.size() > 0) begin
      e = exp_res_q.pop_front(); o = obs_res_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL rz_res got %h want %h", o, e); end
      n_cmp++;
      if (o.code !== 2'd1 || o.fx !== 10'd99 || o.fy !== 10'd99) begin
        n_bad++; $display("FAIL rz_code got code %0d flag (%0d,%0d) want 1 (99,99)", o.code, o.fx, o.fy);
      end
    end
    exp_req_q.delete(); obs_req_q.delete(); exp_res_q.delete(); obs_res_q.delete();
  endtask

  task automatic test_wrap();
    bit ok;
    int n0;
    res_t e, o;
    tbl_dx = '{-5, 5, 0, 0}; tbl_dy = '{-5, 5, 0, 0};
    expect_run(1, 1, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    n0 = n_complete;
    start_run(1, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_done(n0, ok);
    n_cmp++;
    if (obs_req_q.size() == 0 || obs_req_q[0] !== {10'd1020, 10'd1020}) begin
      n_bad++; $display("FAIL wrap_first got %h want (1020,1020) n=%0d",
                        (obs_req_q.size() > 0) ? obs_req_q[0] : '0, obs_req_q.size());
    end
    while (exp_req_q.size() > 0 && obs_req_q.size() > 0) begin
      n_cmp++;
      if (obs_req_q[0] !== exp_req_q[0]) begin
        n_bad++; $display("FAIL wrap_req got %h want %h", obs_req_q[0], exp_req_q[0]);
      end
      void'(obs_req_q.pop_front()); void'(exp_req_q.pop_front());
    end
    n_cmp++;
    if (!ok || obs_res_q.size() == 0 || obs_res_q[0] !== exp_res_q[0]) begin
      n_bad++; $display("FAIL wrap_res got %h want %h done %b",
                        (obs_res_q.size() > 0) ? obs_res_q[0] : '0, exp_res_q[0], ok);
    end
    exp_req_q.delete(); obs_req_q.delete(); exp_res_q.delete(); obs_res_q.delete();
  endtask

  task automatic test_timeout();
    bit ok;
    int n0;
    tbl_dx = '{5, 0, -5, 0}; tbl_dy = '{0, 5, 0, -5};
    hold_num = 2;
    expect_run(100, 100, 1'b0, 1'b1, 1'b0, 1'b1, 2);
    n0 = n_complete;
    start_run(100, 100, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_done(n0, ok);
    n_cmp++;
    if (hold_cyc != TIMEOUT) begin
      n_bad++; $display("FAIL tmo_cycles got %0d want %0d", hold_cyc, TIMEOUT);
    end
    n_cmp++;
    if (obs_req_q.size() != 3 || obs_req_q[2] !== exp_req_q[2]) begin
      n_bad++; $display("FAIL tmo_reqs got %0d want 3", obs_req_q.size());
    end
    n_cmp++;
    if (!ok || obs_res_q.size() == 0 || obs_res_q[0] !== exp_res_q[0]) begin
      n_bad++; $display("FAIL tmo_res got %h want %h done %b",
                        (obs_res_q.size() > 0) ? obs_res_q[0] : '0, exp_res_q[0], ok);
    end
    hold_num = -1;
    exp_req_q.delete(); obs_req_q.delete(); exp_res_q.delete(); obs_res_q.delete();
  endtask

  task automatic test_reset_mid();
    bit seen;
    int n0;
    hold_num = NR;
    n0 = n_complete;
    start_run(100, 100, 1'b0, 1'b1, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (req_in_run > NR) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL rmid_wwait got 0 want 1"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({pt_req, busy, complete, error, err_code} !== 6'b0) begin
      n_bad++; $display("FAIL rmid_ctrl got %b want 000000", {pt_req, busy, complete, error, err_code});
    end
    n_cmp++;
    if ({orien_coords_x, orien_coords_y, flag_coords_x, flag_coords_y, rom_addr} !== '0) begin
      n_bad++; $display("FAIL rmid_outs got %h want 0",
                        {orien_coords_x, orien_coords_y, flag_coords_x, flag_coords_y, rom_addr});
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (n_complete != n0) begin n_bad++; $display("FAIL rmid_pulse got %0d want 0", n_complete - n0); end
    hold_num = -1;
    m_ox = 0; m_oy = 0; m_fx = 0; m_fy = 0;
    exp_req_q.delete(); obs_req_q.delete(); exp_res_q.delete(); obs_res_q.delete();
    test_nominal();
  endtask

  task automatic test_start_ignored();
    bit ok, seen;
    int n0;
    res_t e, o;
    expect_run(100, 100, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    n0 = n_complete;
    start_run(100, 100, 1'b0, 1'b1, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (pt_req) seen = 1'b1;
      else @(negedge clk);
    end
    ctr_coords_x = 10'd300; ctr_coords_y = 10'd300; ring_sel = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n0, ok);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (!seen || n_complete - n0 != 1) begin
      n_bad++; $display("FAIL sti_pulses got %0d want 1", n_complete - n0);
    end
    n_cmp++;
    if (obs_req_q.size() != exp_req_q.size()) begin
      n_bad++; $display("FAIL sti_nreq got %0d want %0d", obs_req_q.size(), exp_req_q.size());
    end
    while (exp_res_q.size() > 0 && obs_res_q.size() > 0) begin
      e = exp_res_q.pop_front(); o = obs_res_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL sti_res got %h want %h", o, e); end
    end
    exp_req_q.delete(); obs_req_q.delete(); exp_res_q.delete(); obs_res_q.delete();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ring_zero();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
